trng_ehr_rd_arbiter: RTL and testbench

//  Owns the TRNG entropy holding register (EHR) read side. Arbitrates between word-wise CPU reads
//  (NUM_WORDS x 32b) and single-shot PRNG reseed reads. Sequences the per-word consume pulses
//  to the bits counter and drives the CPU-mid-read lock that masks EHR-valid toward the PRNG.

---
 rtl/trng_ehr_pkg.sv | 23 ++
 rtl/trng_ehr_rd_timer.sv | 36 +++
 rtl/trng_ehr_rd_arbiter.sv | 183 ++++++++++++++++++
 tb/tb_trng_ehr_rd_arbiter.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/trng_ehr_pkg.sv
// Shared EHR geometry and read-arbiter state encoding for the TRNG EHR read path.
package trng_ehr_pkg;

    localparam int EHR_WIDTH = 192;
    localparam int NUM_WORDS = EHR_WIDTH / 32;
    localparam int IDX_W     = $clog2(NUM_WORDS);

    typedef logic [IDX_W-1:0] word_idx_t;

    localparam word_idx_t LAST_IDX = word_idx_t'(NUM_WORDS - 1);

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_CPU_RD   = 2'd1,
        ST_PRNG_GNT = 2'd2
    } rd_state_e;

    // The index field can encode values beyond the last EHR word.
    function automatic logic idx_in_range(input word_idx_t idx);
        return {1'b0, idx} < (IDX_W + 1)'(NUM_WORDS);
    endfunction

endpackage

// File: rtl/trng_ehr_rd_timer.sv
// Idle-cycle counter for an in-progress CPU EHR read; flags expiry after TIMEOUT_CYCLES
// consecutive enabled cycles. Used only when TRNG_EHR_RD_TIMEOUT_EN is defined.
module trng_ehr_rd_timer #(
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic rng_clk,
    input  logic rst,
    input  logic count_en,
    output logic expired
);

    localparam int CNT_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    assign expired = count_en && (cnt_q == CNT_LAST);

    // Dropping count_en (accepted word, state exit) restarts the count from zero.
    always_comb begin
        cnt_d = '0;
        if (count_en && !expired) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge rng_clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/trng_ehr_rd_arbiter.sv
// TRNG EHR read-side arbiter: CPU word-wise reads vs PRNG reseed, consume pulses and CPU lock.
// Optional idle timeout on CPU reads: define TRNG_EHR_RD_TIMEOUT_EN.
module trng_ehr_rd_arbiter
  import trng_ehr_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic             rng_clk,
  input  logic             rst,
  input  logic             ehr_valid,
  input  logic             rst_trng_logic,
  input  logic             debug_mode,
  input  logic             cpu_rd_req,
  input  logic [IDX_W-1:0] cpu_rd_idx,
  input  logic             prng_req,
  output logic             cpu_rd_ok,
  output logic             cpu_rd_err,
  output logic [IDX_W-1:0] ehr_word_sel,
  output logic             cpu_ehr_rd,
  output logic             prng_trng_ehr_rd,
  output logic             cpu_in_mid_rd_of_ehr_not_in_debug_mode,
  output logic             ehr_flush,
  output logic             timeout_err
);

  rd_state_e state_q, state_d;
  word_idx_t exp_idx_q, exp_idx_d;
  word_idx_t ehr_word_sel_q, ehr_word_sel_d;
  logic      cpu_rd_ok_q, cpu_rd_ok_d;
  logic      cpu_rd_err_q, cpu_rd_err_d;
  logic      cpu_ehr_rd_q, cpu_ehr_rd_d;
  logic      prng_rd_q, prng_rd_d;
  logic      lock_q, lock_d;
  logic      ehr_flush_q, ehr_flush_d;
  logic      timeout_err_q, timeout_err_d;
  logic      ehr_stale_q, ehr_stale_d;

  logic      ehr_avail;
  logic      cpu_accept;
  logic      tmr_expired;

  // ehr_valid may lag the PRNG's clear by a cycle; a stale high level must not re-grant.
  assign ehr_avail  = ehr_valid && !ehr_stale_q;
  assign cpu_accept = (state_q == ST_CPU_RD) && cpu_rd_req && (cpu_rd_idx == exp_idx_q);

`ifdef TRNG_EHR_RD_TIMEOUT_EN
  logic tmr_en;

  assign tmr_en = (state_q == ST_CPU_RD) && !cpu_accept && !rst_trng_logic;

  trng_ehr_rd_timer #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) u_timer (
    .rng_clk  (rng_clk),
    .rst      (rst),
    .count_en (tmr_en),
    .expired  (tmr_expired)
  );
`else
  assign tmr_expired = 1'b0;
`endif

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    state_d        = state_q;
    exp_idx_d      = exp_idx_q;
    ehr_word_sel_d = ehr_word_sel_q;
    cpu_rd_ok_d    = 1'b0;
    cpu_rd_err_d   = 1'b0;
    cpu_ehr_rd_d   = 1'b0;
    prng_rd_d      = 1'b0;
    ehr_flush_d    = 1'b0;
    timeout_err_d  = timeout_err_q;
    ehr_stale_d    = ehr_stale_q && ehr_valid;

    if (rst_trng_logic) begin
      state_d        = ST_IDLE;
      exp_idx_d      = '0;
      ehr_word_sel_d = '0;
      cpu_rd_err_d   = cpu_rd_req;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (ehr_avail && prng_req) begin
            state_d      = ST_PRNG_GNT;
            prng_rd_d    = 1'b1;
            ehr_stale_d  = 1'b1;
            cpu_rd_err_d = cpu_rd_req;
          end else if (cpu_rd_req) begin
            if (!ehr_avail || !idx_in_range(cpu_rd_idx)) begin
              cpu_rd_err_d = 1'b1;
            end else if (debug_mode) begin
              cpu_rd_ok_d    = 1'b1;
              ehr_word_sel_d = cpu_rd_idx;
            end else if (cpu_rd_idx == '0) begin
              state_d        = ST_CPU_RD;
              exp_idx_d      = word_idx_t'(1);
              cpu_rd_ok_d    = 1'b1;
              cpu_ehr_rd_d   = 1'b1;
              ehr_word_sel_d = '0;
            end else begin
              cpu_rd_err_d = 1'b1;
            end
          end
        end

        ST_PRNG_GNT: begin
          state_d      = ST_IDLE;
          cpu_rd_err_d = cpu_rd_req;
        end

        ST_CPU_RD: begin
          if (cpu_accept) begin
            cpu_rd_ok_d    = 1'b1;
            cpu_ehr_rd_d   = 1'b1;
            ehr_word_sel_d = cpu_rd_idx;
            if (exp_idx_q == LAST_IDX) begin
              state_d   = ST_IDLE;
              exp_idx_d = '0;
            end else begin
              exp_idx_d = exp_idx_q + word_idx_t'(1);
            end
          end else begin
            cpu_rd_err_d = cpu_rd_req;
            if (tmr_expired) begin
              state_d       = ST_IDLE;
              exp_idx_d     = '0;
              ehr_flush_d   = 1'b1;
              timeout_err_d = 1'b1;
            end
          end
        end

        default: begin
          state_d   = ST_IDLE;
          exp_idx_d = '0;
        end
      endcase
    end

    // Lock tracks the registered state, so it drops together with the last word's ok.
    lock_d = (state_d == ST_CPU_RD);
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge rng_clk) begin
    if (rst) begin
      state_q        <= ST_IDLE;
      exp_idx_q      <= '0;
      ehr_word_sel_q <= '0;
      cpu_rd_ok_q    <= 1'b0;
      cpu_rd_err_q   <= 1'b0;
      cpu_ehr_rd_q   <= 1'b0;
      prng_rd_q      <= 1'b0;
      lock_q         <= 1'b0;
      ehr_flush_q    <= 1'b0;
      timeout_err_q  <= 1'b0;
      ehr_stale_q    <= 1'b0;
    end else begin
      state_q        <= state_d;
      exp_idx_q      <= exp_idx_d;
      ehr_word_sel_q <= ehr_word_sel_d;
      cpu_rd_ok_q    <= cpu_rd_ok_d;
      cpu_rd_err_q   <= cpu_rd_err_d;
      cpu_ehr_rd_q   <= cpu_ehr_rd_d;
      prng_rd_q      <= prng_rd_d;
      lock_q         <= lock_d;
      ehr_flush_q    <= ehr_flush_d;
      timeout_err_q  <= timeout_err_d;
      ehr_stale_q    <= ehr_stale_d;
    end
  end

  assign cpu_rd_ok                              = cpu_rd_ok_q;
  assign cpu_rd_err                             = cpu_rd_err_q;
  assign ehr_word_sel                           = ehr_word_sel_q;
  assign cpu_ehr_rd                             = cpu_ehr_rd_q;
  assign prng_trng_ehr_rd                       = prng_rd_q;
  assign cpu_in_mid_rd_of_ehr_not_in_debug_mode = lock_q;
  assign ehr_flush                              = ehr_flush_q;
  assign timeout_err                            = timeout_err_q;

endmodule

// File: tb/tb_trng_ehr_rd_arbiter.sv
// Directed self-checking bench for trng_ehr_rd_arbiter (timeout scenario built with
// TIMEOUT_CYCLES=16 when TRNG_EHR_RD_TIMEOUT_EN is defined).
module tb_trng_ehr_rd_arbiter;

  logic       rng_clk = 1'b0;
  logic       rst;
  logic       ehr_valid;
  logic       rst_trng_logic;
  logic       debug_mode;
  logic       cpu_rd_req;
  logic [2:0] cpu_rd_idx;
  logic       prng_req;
  logic       cpu_rd_ok;
  logic       cpu_rd_err;
  logic [2:0] ehr_word_sel;
  logic       cpu_ehr_rd;
  logic       prng_trng_ehr_rd;
  logic       lock;
  logic       ehr_flush;
  logic       timeout_err;

  int n_checks = 0;
  int n_errors = 0;

  always #5 rng_clk = ~rng_clk;

  trng_ehr_rd_arbiter #(.TIMEOUT_CYCLES(16)) dut (
    .rng_clk                                (rng_clk),
    .rst                                    (rst),
    .ehr_valid                              (ehr_valid),
    .rst_trng_logic                         (rst_trng_logic),
    .debug_mode                             (debug_mode),
    .cpu_rd_req                             (cpu_rd_req),
    .cpu_rd_idx                             (cpu_rd_idx),
    .prng_req                               (prng_req),
    .cpu_rd_ok                              (cpu_rd_ok),
    .cpu_rd_err                             (cpu_rd_err),
    .ehr_word_sel                           (ehr_word_sel),
    .cpu_ehr_rd                             (cpu_ehr_rd),
    .prng_trng_ehr_rd                       (prng_trng_ehr_rd),
    .cpu_in_mid_rd_of_ehr_not_in_debug_mode (lock),
    .ehr_flush                              (ehr_flush),
    .timeout_err                            (timeout_err)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance one edge; outputs then hold the response to the inputs sampled at that edge.
  task automatic tick();
    @(posedge rng_clk);
    #1;
  endtask

  task automatic cpu_req(input logic [2:0] idx);
    cpu_rd_req = 1'b1;
    cpu_rd_idx = idx;
    tick();
    cpu_rd_req = 1'b0;
  endtask

  task automatic expect_resp(input string tag, input logic ok, input logic err,
                             input logic rd, input logic prng, input logic lk);
    check({tag, ".ok"},   cpu_rd_ok,        ok);
    check({tag, ".err"},  cpu_rd_err,       err);
    check({tag, ".rd"},   cpu_ehr_rd,       rd);
    check({tag, ".prng"}, prng_trng_ehr_rd, prng);
    check({tag, ".lock"}, lock,             lk);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst            = 1'b1;
    ehr_valid      = 1'b0;
    rst_trng_logic = 1'b0;
    debug_mode     = 1'b0;
    cpu_rd_req     = 1'b0;
    cpu_rd_idx     = 3'd0;
    prng_req       = 1'b0;
    tick();
    tick();
    expect_resp("reset", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    check("reset.sel",   ehr_word_sel, 3'd0);
    check("reset.flush", ehr_flush,    1'b0);
    check("reset.terr",  timeout_err,  1'b0);
    rst = 1'b0;
    tick();

    // 1: full CPU read, words 0..5 back to back
    ehr_valid = 1'b1;
    for (int i = 0; i < 6; i++) begin
      cpu_req(3'(i));
      ehr_valid = 1'b0;
      expect_resp($sformatf("t1.w%0d", i), 1'b1, 1'b0, 1'b1, 1'b0, (i < 5));
      check($sformatf("t1.sel%0d", i), ehr_word_sel, 32'(i));
    end
    tick();
    expect_resp("t1.after", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    cpu_req(3'd1);
    expect_resp("t1.idle_err", 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);

    // 2: PRNG beats simultaneous CPU word-0 read; no re-grant on a stale ehr_valid
    ehr_valid = 1'b1;
    prng_req  = 1'b1;
    cpu_req(3'd0);
    expect_resp("t2.grant", 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
    tick();
    expect_resp("t2.gnt_end", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    check("t2.no_regrant", prng_trng_ehr_rd, 1'b0);
    ehr_valid = 1'b0;
    tick();
    check("t2.valid_low", prng_trng_ehr_rd, 1'b0);
    ehr_valid = 1'b1;
    tick();
    check("t2.regrant", prng_trng_ehr_rd, 1'b1);
    prng_req  = 1'b0;
    ehr_valid = 1'b0;
    tick();
    tick();

    // 3: out-of-order index rejected mid-read; PRNG masked by lock
    ehr_valid = 1'b1;
    cpu_req(3'd0);
    expect_resp("t3.w0", 1'b1, 1'b0, 1'b1, 1'b0, 1'b1);
    ehr_valid = 1'b0;
    cpu_req(3'd1);
    expect_resp("t3.w1", 1'b1, 1'b0, 1'b1, 1'b0, 1'b1);
    cpu_req(3'd3);
    expect_resp("t3.w3_bad", 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
    prng_req  = 1'b1;
    ehr_valid = 1'b1;
    cpu_req(3'd2);
    expect_resp("t3.w2", 1'b1, 1'b0, 1'b1, 1'b0, 1'b1);
    check("t3.sel2", ehr_word_sel, 3'd2);
    tick();
    expect_resp("t3.masked", 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    prng_req  = 1'b0;
    ehr_valid = 1'b0;

    // 4: rst_trng_logic aborts the read
    rst_trng_logic = 1'b1;
    tick();
    expect_resp("t4.abort", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    rst_trng_logic = 1'b0;
    cpu_req(3'd3);
    expect_resp("t4.w3_err", 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    rst_trng_logic = 1'b1;
    ehr_valid      = 1'b1;
    cpu_req(3'd0);
    expect_resp("t4.req_in_rst", 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    rst_trng_logic = 1'b0;
    ehr_valid      = 1'b0;
    tick();

    // 5: debug reads do not consume or lock; out-of-range index always rejected
    debug_mode = 1'b1;
    ehr_valid  = 1'b1;
    cpu_req(3'd4);
    expect_resp("t5.d4a", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    check("t5.sel4a", ehr_word_sel, 3'd4);
    cpu_req(3'd0);
    expect_resp("t5.d0", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    check("t5.sel0", ehr_word_sel, 3'd0);
    cpu_req(3'd4);
    expect_resp("t5.d4b", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    cpu_req(3'd6);
    expect_resp("t5.d6", 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    debug_mode = 1'b0;
    cpu_req(3'd7);
    expect_resp("t5.idx7", 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    ehr_valid = 1'b0;
    tick();

    // 6: stalled CPU read; flushes after 16 idle cycles only with the timeout built in
    begin
      int flush_cnt;
      int flush_at;
      flush_cnt = 0;
      flush_at  = 0;
      ehr_valid = 1'b1;
      cpu_req(3'd0);
      expect_resp("t6.w0", 1'b1, 1'b0, 1'b1, 1'b0, 1'b1);
      ehr_valid = 1'b0;
      for (int k = 1; k <= 24; k++) begin
        tick();
        if (ehr_flush) begin
          flush_cnt++;
          if (flush_at == 0) flush_at = k;
        end
      end
`ifdef TRNG_EHR_RD_TIMEOUT_EN
      check("t6.flush_cnt", flush_cnt,   1);
      check("t6.flush_at",  flush_at,    16);
      check("t6.terr",      timeout_err, 1'b1);
      check("t6.lock",      lock,        1'b0);
      cpu_req(3'd1);
      check("t6.idle_err",  cpu_rd_err,  1'b1);
`else
      check("t6.flush_cnt", flush_cnt,   0);
      check("t6.terr",      timeout_err, 1'b0);
      check("t6.lock_held", lock,        1'b1);
      cpu_req(3'd1);
      check("t6.w1_late",   cpu_rd_ok,   1'b1);
`endif
      rst_trng_logic = 1'b1;
      tick();
      rst_trng_logic = 1'b0;
      check("t6.lock_off", lock, 1'b0);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
